// File: rtl/traffic_request_conditioner.sv
// Synchronises, debounces and edge-detects the walk button and vehicle sensor,
// holding sticky requests until acknowledged. Optional walk lockout: WALK_LOCKOUT_EN.
module traffic_request_conditioner #(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned DEB_CYCLES    = 8,
  parameter int unsigned LOCKOUT_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       walk_btn,
  input  logic       sensor_in,
  input  logic       walk_ack,
  input  logic       sensor_ack,
  output logic       walk_req,
  output logic       sensor_req,
  output logic       sensor_level,
  output logic [3:0] press_cnt,
  output logic       tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam int unsigned WALK = 0;
  localparam int unsigned SENS = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [1:0]       raw;
  logic [1:0]       ack;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db;
  logic [1:0]       db_q;
  logic [1:0]       rise;
  logic [1:0]       fsm_rise;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] deb_cnt [2];
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  assign raw = {sensor_in, walk_btn};
  assign ack = {sensor_ack, walk_ack};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // tick is registered from the next divider value so it is high exactly
  // while div sits at its last count (every cycle when TICK_DIV is 1).
  always_comb begin
    div_next = '0;
    if (div != DIV_LAST)
      div_next = DIV_W'(div + 1'b1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      div  <= div_next;
      tick <= (div_next == DIV_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '0;
      for (int unsigned i = 0; i < 2; i++)
        deb_cnt[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            db[i]      <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= CNT_W'(deb_cnt[i] + 1'b1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      db_q <= '0;
    else
      db_q <= db;
  end

  assign rise = db & ~db_q;

`ifdef WALK_LOCKOUT_EN
  localparam int unsigned LK_W = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;

  logic [LK_W-1:0] lock_cnt;

  // Loaded on the acknowledge edge, so a rise coinciding with ack still re-arms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lock_cnt <= '0;
    else if (state[WALK] == PEND && ack[WALK])
      lock_cnt <= LK_W'(LOCKOUT_TICKS);
    else if (tick && lock_cnt != '0)
      lock_cnt <= LK_W'(lock_cnt - 1'b1);
  end

  assign fsm_rise = {rise[SENS], rise[WALK] & (lock_cnt == '0)};
`else
  logic unused_lockout;

  assign unused_lockout = ^LOCKOUT_TICKS;
  assign fsm_rise       = rise;
`endif

  always_comb begin
    state_next = state;
    for (int unsigned i = 0; i < 2; i++) begin
      case (state[i])
        IDLE:    if (fsm_rise[i]) state_next[i] = PEND;
        default: if (ack[i] && !fsm_rise[i]) state_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= {IDLE, IDLE};
    else
      state <= state_next;
  end

  assign walk_req     = (state[WALK] == PEND);
  assign sensor_req   = (state[SENS] == PEND);
  assign sensor_level = db[SENS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      press_cnt <= '0;
    else if (rise[WALK] && press_cnt != 4'hF)
      press_cnt <= press_cnt + 4'd1;
  end

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner: TICK_DIV=1, DEB_CYCLES=4, LOCKOUT_TICKS=10.
module tb_traffic_request_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       walk_btn = 1'b0;
  logic       sensor_in = 1'b0;
  logic       walk_ack = 1'b0;
  logic       sensor_ack = 1'b0;
  logic       walk_req;
  logic       sensor_req;
  logic       sensor_level;
  logic [3:0] press_cnt;
  logic       tick;

  int unsigned total = 0;
  int unsigned bad   = 0;

  traffic_request_conditioner #(
    .TICK_DIV      (1),
    .DEB_CYCLES    (4),
    .LOCKOUT_TICKS (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .walk_btn     (walk_btn),
    .sensor_in    (sensor_in),
    .walk_ack     (walk_ack),
    .sensor_ack   (sensor_ack),
    .walk_req     (walk_req),
    .sensor_req   (sensor_req),
    .sensor_level (sensor_level),
    .press_cnt    (press_cnt),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        wb, si, wa, sa;
    logic        ewr, esr, esl;
    logic [3:0]  epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int unsigned cyc, input logic wb, input logic si,
                     input logic wa, input logic sa, input logic ewr,
                     input logic esr, input logic esl, input logic [3:0] epc);
    vec_t v;
    v.cyc = cyc; v.wb = wb; v.si = si; v.wa = wa; v.sa = sa;
    v.ewr = ewr; v.esr = esr; v.esl = esl; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_all(input string nm, input logic ewr, input logic esr,
                         input logic esl, input logic [3:0] epc);
    chk({nm, "_walk_req"}, {3'b0, walk_req}, {3'b0, ewr});
    chk({nm, "_sensor_req"}, {3'b0, sensor_req}, {3'b0, esr});
    chk({nm, "_sensor_level"}, {3'b0, sensor_level}, {3'b0, esl});
    chk({nm, "_press_cnt"}, press_cnt, epc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_pc;
    logic       lock_wr;

    // walk then glitch, sensor, ack coinciding with a new sensor rise
    add(3,  0,0,0,0, 0,0,0,4'd0);
    add(6,  1,0,0,0, 0,0,0,4'd0);
    add(1,  1,0,0,0, 1,0,0,4'd1);
    add(13, 1,0,0,0, 1,0,0,4'd1);
    add(10, 0,0,0,0, 1,0,0,4'd1);
    add(1,  0,0,1,0, 0,0,0,4'd1);
    add(1,  0,0,0,0, 0,0,0,4'd1);
    add(1,  0,0,1,0, 0,0,0,4'd1);
    add(2,  0,0,0,0, 0,0,0,4'd1);
    add(3,  1,0,0,0, 0,0,0,4'd1);
    add(10, 0,0,0,0, 0,0,0,4'd1);
    add(5,  0,1,0,0, 0,0,0,4'd1);
    add(1,  0,1,0,0, 0,0,1,4'd1);
    add(1,  0,1,0,0, 0,1,1,4'd1);
    add(5,  0,0,0,0, 0,1,1,4'd1);
    add(1,  0,0,0,0, 0,1,0,4'd1);
    add(4,  0,0,0,0, 0,1,0,4'd1);
    add(6,  0,1,0,0, 0,1,1,4'd1);
    add(1,  0,1,0,1, 0,1,1,4'd1);
    add(3,  0,1,0,0, 0,1,1,4'd1);
    add(1,  0,1,0,1, 0,0,1,4'd1);
    add(2,  0,1,0,0, 0,0,1,4'd1);

    @(negedge clk);
    chk_all("reset", 0, 0, 0, 4'd0);
    chk("reset_tick", {3'b0, tick}, 4'd0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("tick_running", {3'b0, tick}, 4'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      walk_btn   = vecs[i].wb;
      sensor_in  = vecs[i].si;
      walk_ack   = vecs[i].wa;
      sensor_ack = vecs[i].sa;
      step(vecs[i].cyc);
      chk_all($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].esr, vecs[i].esl, vecs[i].epc);
    end

    // saturation of press_cnt; requests stay merged while unacknowledged
    sensor_in = 1'b0;
    exp_pc = 4'd1;
    for (int k = 1; k <= 17; k++) begin
      walk_btn = 1'b1;
      step(8);
      walk_btn = 1'b0;
      step(8);
      if (exp_pc != 4'hF) exp_pc = exp_pc + 4'd1;
      chk($sformatf("sat_press%0d", k), press_cnt, exp_pc);
    end
    chk("sat_walk_req", {3'b0, walk_req}, 4'd1);

    // asynchronous reset in the middle of a press
    walk_btn  = 1'b1;
    sensor_in = 1'b1;
    step(7);
    chk_all("pre_reset", 1, 1, 1, 4'hF);
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 4'd0);
    chk("async_reset_tick", {3'b0, tick}, 4'd0);
    walk_btn  = 1'b0;
    sensor_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(3);

    // press right after ack: blocked only when the lockout is built in
`ifdef WALK_LOCKOUT_EN
    lock_wr = 1'b0;
`else
    lock_wr = 1'b1;
`endif
    walk_btn = 1'b1;
    step(7);
    chk_all("lk_press1", 1, 0, 0, 4'd1);
    walk_btn = 1'b0;
    step(8);
    walk_ack = 1'b1;
    step(1);
    chk("lk_ack", {3'b0, walk_req}, 4'd0);
    walk_ack = 1'b0;
    walk_btn = 1'b1;
    step(7);
    chk_all("lk_press2", lock_wr, 0, 0, 4'd2);
    step(13);
    walk_btn = 1'b0;
    step(10);
    chk("lk_hold", {3'b0, walk_req}, {3'b0, lock_wr});
    walk_ack = 1'b1;
    step(1);
    walk_ack = 1'b0;
    chk("lk_clear", {3'b0, walk_req}, 4'd0);
    walk_btn = 1'b1;
    step(6);
    chk("lk_press3_early", {3'b0, walk_req}, 4'd0);
    step(1);
    chk_all("lk_press3", 1, 0, 0, 4'd3);
    walk_btn = 1'b0;
    step(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_request_conditioner.md
Name: traffic_request_conditioner

Overview:
- Input-conditioning stage directly upstream of the traffic cycle controller.
- Takes the raw pedestrian walk button and the raw side-road vehicle sensor. Synchronises and debounces both, then turns debounced rising edges into sticky request levels.
- The controller clears each request with a one-cycle acknowledge.
- Also provides the debounced sensor level and a saturating walk-press count for display/debug.

Parameters:
TICK_DIV, 50000, clk cycles per debounce sample tick (>=1; 1 = sample every cycle)
DEB_CYCLES, 8, consecutive mismatching ticks required to accept a new input level (>=1)
LOCKOUT_TICKS, 64, sample ticks walk presses are ignored after walk_ack (used only with WALK_LOCKOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
walk_btn  in  1  raw pedestrian push-button, asynchronous
sensor_in  in  1  raw vehicle sensor, asynchronous
walk_ack  in  1  one-cycle pulse from controller: walk request consumed
sensor_ack  in  1  one-cycle pulse from controller: sensor request consumed
walk_req  out  1  sticky pedestrian request
sensor_req  out  1  sticky vehicle request
sensor_level  out  1  debounced sensor level
press_cnt  out  4  debounced walk presses since reset, saturating
tick  out  1  one-cycle sample strobe, exported for the controller's timebase

Behaviour:
- Reset (reset=0, async): every flop clears to 0. This includes all sync stages, the tick counter, debounce counts and levels, edge-detect flops, both request FSMs, press_cnt and the lockout counter. All outputs are 0.
- Synchroniser: each raw input passes two flops. The second flop output is called s_walk / s_sensor.
- Tick generator:
  - div counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle the counter equals TICK_DIV-1, registered.
  - TICK_DIV=1 gives tick=1 every cycle after reset release.
- Debouncer (per channel, state db level + count of width clog2(DEB_CYCLES+1)):
  - Counting happens only on cycles with tick=1.
  - If s != db, count increments. When count would reach DEB_CYCLES, db <= s and count <= 0.
  - If s == db on a tick, count <= 0, so any glitch restarts the count.
- Edge detect: rise = db & ~db_q, where db_q is db delayed one cycle. rise is high for exactly one cycle.
- Request FSM (per channel), states IDLE (req=0) and PEND (req=1); req is registered from state.
  - IDLE: rise -> PEND. ack -> ignored.
  - PEND: ack with no rise -> IDLE. rise with no ack -> stay PEND; presses merge and no second request is queued.
  - PEND: ack and rise in the same cycle -> stay PEND; the new press re-arms the request.
  - req falls on the cycle after ack is sampled.
- Latency, TICK_DIV=1: walk_req rises on the (DEB_CYCLES+3)th clk edge, counting the first edge that samples walk_btn=1.
- press_cnt: increments on every walk rise, including merged ones. Holds at 15.
- sensor_level = sensor db, registered.
- Falling edges of db produce no request.
- Reset mid-operation: pending requests are lost; walk_req and sensor_req drop immediately (async).

Optional Feature:
Macro: WALK_LOCKOUT_EN
- Defined:
  - On walk_ack accepted in PEND, a lockout counter loads LOCKOUT_TICKS and decrements on each tick until 0.
  - While it is nonzero, walk rise is ignored by the FSM. press_cnt still counts these presses.
  - sensor channel is unaffected.
  - A rise on the same cycle as ack still re-arms, since lockout starts the following cycle.
- Undefined: no lockout counter exists; walk behaves exactly as the sensor channel.

Test Plan:
- TICK_DIV=1, DEB_CYCLES=4, walk_btn 0->1 held 20 cycles -> walk_req=1 after 7th edge, press_cnt=1, stays 1 until ack.
- Same config, walk_btn high for 3 cycles then low -> walk_req stays 0, press_cnt=0.
- walk_req=1, pulse walk_ack one cycle -> walk_req=0 next cycle. Second walk_ack while idle -> no change.
- sensor_req=1, new debounced sensor rise in the same cycle as sensor_ack -> sensor_req remains 1. sensor_level tracks sensor_in with 6-edge latency.
- 17 clean walk presses (each held and released >=6 cycles) -> press_cnt saturates at 15. Assert reset=0 mid-press -> all outputs 0 immediately.
- With WALK_LOCKOUT_EN, LOCKOUT_TICKS=10: press during lockout after ack -> walk_req stays 0, press_cnt increments. Press after 10 ticks -> walk_req=1.
